load_store_unit: RTL
====================

# load_store_unit

Load/store unit between the ALU result and data memory of the RV32I core. It accepts one access per request, decodes funct3 into byte enables and lane steering, runs a request/acknowledge handshake with a variable-latency data memory, and returns sign- or zero-extended load data to the writeback mux. The core holds its PC while `busy` is high.

## Interface
- `TIMEOUT`, 255: cycles of `mem_req` without `mem_ack` before the access is aborted with an error; range 1–255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  core issues an access.
- `req_ready`  out  1  LSU idle and able to accept.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  instruction funct3.
- `req_addr`  in  32  byte address (ALU output).
- `req_wdata`  in  32  store data (rs2).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  qualifies `rsp_valid`: illegal funct3, misaligned address, or timeout.
- `busy`  out  1  state ≠ IDLE.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  32  word address: `{req_addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_ack`  in  1  memory done; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  raw memory word.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid`, register we, funct3, addr and wdata.
  - Illegal or misaligned request → RESP with err; no memory cycle.
  - Otherwise → WAIT.
- **WAIT**
  - `mem_req=1`; all `mem_*` outputs stay stable.
  - On `mem_ack`, register the extended data → RESP.
  - Timeout counter clears on entry and increments each WAIT cycle without ack.
  - Count reaching `TIMEOUT` → RESP with err; `mem_req` drops.
- **RESP**
  - `rsp_valid=1` for exactly one cycle, then → IDLE.
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Legal stores: 000 sb, 001 sh, 010 sw.
- Any other funct3 is illegal.
- Store steering:
  - sb: wdata `{4{d[7:0]}}`, be `4'b0001<<addr[1:0]`.
  - sh: wdata `{2{d[15:0]}}`, be `addr[1]?1100:0011`.
  - sw: be `1111`.
- Loads: `mem_be=1111`. Select the byte/half at offset `addr[1:0]` (half uses `addr[1]`), then sign-extend (lb/lh) or zero-extend (lbu/lhu).
- `mem_ack` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `req_ready`, `rsp_valid`, `rsp_err`, `busy`, `mem_req`, `mem_we` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be`=0; counter 0.
- `req_ready` is 0 while `rst` is high.
- Latency:
  - Accept at edge T0 → `mem_req` high in cycle T1.
  - Ack sampled at edge Tn → `rsp_valid` in cycle Tn+1.
  - Zero-wait memory gives `rsp_valid` 2 cycles after acceptance.
- Error without memory access: `rsp_valid` 1 cycle after acceptance.
- Throughput: at most one access per 3 cycles; `req_ready=0` in WAIT and RESP.
- Ack in the same cycle the count reaches `TIMEOUT`: ack wins, no error.
- Reset mid-WAIT: `mem_req` low in the next cycle; no `rsp_valid` is produced.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - half with `addr[0]=1`, or word with `addr[1:0]≠0`, → `rsp_err`; memory is untouched.
- Undefined:
  - no misalignment check; half ignores `addr[0]`, word ignores `addr[1:0]`.
  - The access proceeds normally.
- Illegal-funct3 errors and timeouts are present in both builds.

## Structure
- `lsu_pkg` holds:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state enum `lsu_state_t`;
  - the counter width (8).
- Sub-module `lsu_align`: purely combinational store replication / byte-enable generation and load extraction / extension, instantiated once.
- FSM, capture registers and timeout counter live in the top module.

## Test plan
- sb, addr `0x103`, wdata `0x000000A5`, ack after 0 waits → `mem_be=1000`, `mem_wdata=0xA5A5A5A5`, `mem_addr=0x100`, `rsp_valid` 2 cycles after accept, `rsp_err=0`.
- lb at `0x102`, `mem_rdata=0x00800000` → `rsp_rdata=0xFFFFFF80`; lbu same → `0x00000080`; lhu at `0x102` with `0x8001_0000` → `0x00008001`.
- lw at `0x200`, ack after 5 wait cycles → `mem_req` high for 6 cycles with stable addr, `rsp_rdata=mem_rdata`.
- lw with `mem_ack` never asserted, `TIMEOUT=4` → `mem_req` high 4 cycles, then `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`.
- lh at `0x101`: with the macro → err 1 cycle after accept, `mem_req` never asserted; without it → access at `0x100`, `be` for the load `1111`, lower half returned.
- funct3 `011` load, then `rst` asserted during WAIT of a following sw → err response for the first; `mem_req` drops the cycle after reset, no `rsp_valid`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Stores only have signed-width encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface lsu_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational store lane replication / byte enables and load extraction / extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata_c,
  output logic [3:0]  st_be_c,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    st_wdata_c = st_data;
    st_be_c    = 4'b1111;
    if (we) begin
      case (st_funct3)
        F3_B: begin
          st_wdata_c = {4{st_data[7:0]}};
          st_be_c    = 4'b0001 << st_off;
        end
        F3_H: begin
          st_wdata_c = {2{st_data[15:0]}};
          st_be_c    = st_off[1] ? 4'b1100 : 4'b0011;
        end
        default: ;
      endcase
    end
  end

  // Half-word selection ignores bit 0 of the offset.
  always_comb begin
    byte_c = ld_raw[{ld_off, 3'b000} +: 8];
    half_c = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_funct3)
      F3_B:    ld_data_c = {{24{byte_c[7]}}, byte_c};
      F3_H:    ld_data_c = {{16{half_c[15]}}, half_c};
      F3_W:    ld_data_c = ld_raw;
      F3_BU:   ld_data_c = {24'h0, byte_c};
      F3_HU:   ld_data_c = {16'h0, half_c};
      default: ld_data_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: request capture, memory handshake with timeout, load writeback.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  lsu_mem_if.master   mem
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t       state;
  logic             cap_we;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_off;
  logic [CNT_W-1:0] cnt;
  logic             mem_req_q, mem_we_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      st_wdata_c, ld_data_c;
  logic [3:0]       st_be_c;
  logic             misalign_c, bad_c;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                      ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign bad_c = !f3_legal(req_we, req_funct3) || misalign_c;

  lsu_align u_align (
    .we         (req_we),
    .st_funct3  (req_funct3),
    .st_off     (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_wdata_c (st_wdata_c),
    .st_be_c    (st_be_c),
    .ld_funct3  (cap_f3),
    .ld_off     (cap_off),
    .ld_raw     (mem.rdata),
    .ld_data_c  (ld_data_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0;
      busy        <= 1'b0;
      cap_we      <= 1'b0;
      cap_f3      <= 3'b000;
      cap_off     <= 2'b00;
      cnt         <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          // req_ready also comes up here on the first cycle after reset.
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_off   <= req_addr[1:0];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (bad_c) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state       <= WAIT;
              cnt         <= '0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= st_wdata_c;
              mem_be_q    <= st_be_c;
            end
          end
        end
        WAIT: begin
          // A late ack takes priority over an expiring timeout.
          if (mem.ack) begin
            state     <= RESP;
            mem_req_q <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= cap_we ? 32'h0 : ld_data_c;
          end else if (cnt == CNT_LAST) begin
            state     <= RESP;
            mem_req_q <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.req   = mem_req_q;
  assign mem.we    = mem_we_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;
  assign mem.be    = mem_be_q;

endmodule
